// File: rtl/ram_tap_sequencer_pkg.sv
// Shared constants, state encoding and width helper for the RAM tap sequencer
// and the IIR top that embeds it.
package ram_tap_sequencer_pkg;

    localparam int unsigned DefEleNum    = 8;
    localparam int unsigned DefDataWidth = 6;
    localparam int unsigned DefTaps      = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2
    } state_e;

    // Never returns 0 so a single-word RAM still gets a 1-bit address.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ram_tap_sequencer_if.sv
// Sample source, RAM port and tap stream of the tap sequencer bundled together;
// master is the sequencer side, slave is the source/RAM/MAC side.
interface ram_tap_sequencer_if
    import ram_tap_sequencer_pkg::*;
#(
    parameter int unsigned eleNum    = DefEleNum,
    parameter int unsigned dataWidth = DefDataWidth
);
    localparam int unsigned addWidth = log2_ceil(eleNum);

    logic                 s_valid;
    logic                 s_ready;
    logic [dataWidth-1:0] s_data;
    logic                 ram_we;
    logic [addWidth-1:0]  ram_addr;
    logic [dataWidth-1:0] ram_din;
    logic [dataWidth-1:0] ram_dout;
    logic                 tap_valid;
    logic                 tap_ready;
    logic [dataWidth-1:0] tap_data;
    logic [addWidth:0]    tap_idx;
    logic                 tap_last;

    modport master (
        input  s_valid, s_data, ram_dout, tap_ready,
        output s_ready, ram_we, ram_addr, ram_din, tap_valid, tap_data, tap_idx, tap_last
    );

    modport slave (
        output s_valid, s_data, ram_dout, tap_ready,
        input  s_ready, ram_we, ram_addr, ram_din, tap_valid, tap_data, tap_idx, tap_last
    );

endinterface

// File: rtl/ram_tap_sequencer.sv
// Circular delay line controller: writes each accepted sample once, then streams
// TAPS reads newest-first from the attached async-read RAM.
module ram_tap_sequencer
    import ram_tap_sequencer_pkg::*;
#(
    parameter int unsigned eleNum    = DefEleNum,
    parameter int unsigned dataWidth = DefDataWidth,
    parameter int unsigned TAPS      = DefTaps
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram_tap_sequencer_if.master  bus
);
    localparam int unsigned       addWidth = log2_ceil(eleNum);
    localparam logic [addWidth:0] LastK    = (addWidth + 1)'(TAPS - 1);

    state_e               state_q, state_d;
    logic [addWidth-1:0]  wptr_q, wptr_d;
    logic [addWidth:0]    k_q, k_d;
    logic [dataWidth-1:0] sample_q, sample_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            wptr_q   <= '0;
            k_q      <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            k_q      <= k_d;
            sample_q <= sample_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        k_d           = k_q;
        sample_d      = sample_q;
        bus.s_ready   = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_addr  = wptr_q;
        bus.tap_valid = 1'b0;
        bus.tap_last  = 1'b0;
        case (state_q)
            StIdle: begin
                // RST term keeps s_ready low for the whole reset pulse.
                bus.s_ready = RST;
                if (bus.s_valid && RST) begin
                    sample_d = bus.s_data;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                bus.ram_we = 1'b1;
                k_d        = '0;
                state_d    = StRead;
            end
            StRead: begin
                bus.ram_addr  = wptr_q - k_q[addWidth-1:0];
                bus.tap_valid = 1'b1;
                bus.tap_last  = (k_q == LastK);
                if (bus.tap_ready) begin
                    if (k_q == LastK) begin
                        wptr_d  = wptr_q + 1'b1;
                        k_d     = '0;
                        state_d = StIdle;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.ram_din  = sample_q;
    assign bus.tap_data = bus.ram_dout;
    assign bus.tap_idx  = k_q;

endmodule

// File: tb/tb_ram_tap_sequencer.sv
// Self-checking bench: vector table, directed corner cases and randomized
// traffic against a sample-history model, with TAPS=4 and TAPS=8 instances.
module tb_ram_tap_sequencer;
    import ram_tap_sequencer_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    ram_tap_sequencer_if #(.eleNum(8), .dataWidth(6)) bus4 ();
    ram_tap_sequencer_if #(.eleNum(8), .dataWidth(6)) bus8 ();

    ram_tap_sequencer #(.eleNum(8), .dataWidth(6), .TAPS(4)) dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4)
    );

    ram_tap_sequencer #(.eleNum(8), .dataWidth(6), .TAPS(8)) dut8 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus8)
    );

    // RAM_ar stand-ins: async read, sync write, contents cleared by reset.
    logic [5:0] mem4 [8];
    logic [5:0] mem8 [8];
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 8; i++) begin
                mem4[i] <= '0;
                mem8[i] <= '0;
            end
        end else begin
            if (bus4.ram_we) mem4[bus4.ram_addr] <= bus4.ram_din;
            if (bus8.ram_we) mem8[bus8.ram_addr] <= bus8.ram_din;
        end
    end
    assign bus4.ram_dout = mem4[bus4.ram_addr];
    assign bus8.ram_dout = mem8[bus8.ram_addr];

    int total = 0;
    int bad   = 0;
    int hist[$];
    int tapcnt  = 0;
    int writes  = 0;
    int accepts = 0;
    int tap8[$];
    int addr8[$];

    typedef struct {
        logic       sv;
        logic [5:0] sd;
        logic       tr;
        logic       e_sr;
        logic       e_we;
        logic [2:0] e_addr;
        logic [5:0] e_din;
        logic       e_tv;
        logic [3:0] e_idx;
        logic       e_last;
        logic [5:0] e_data;
    } vec_t;
    vec_t vecs [22];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout, required handshake", name);
    endtask

    task automatic model_reset();
        hist.delete();
        tapcnt = 0;
        tap8.delete();
        addr8.delete();
    endtask

    // Expected tap k of the newest sample n is sample n-k, stored at (n-k) mod 8;
    // samples that predate the reset read as 0.
    task automatic scoreboard();
        int n, k, j;
        n = hist.size();
        if (bus4.ram_we) begin
            writes++;
            if (n == 0) begin
                timeout("write_without_sample");
            end else begin
                check("wr_addr", int'(bus4.ram_addr), (n - 1) & 7);
                check("wr_din", int'(bus4.ram_din), hist[n-1]);
            end
        end
        if (bus4.tap_valid && bus4.tap_ready) begin
            k = tapcnt % 4;
            j = n - 1 - k;
            check("tap_idx", int'(bus4.tap_idx), k);
            check("tap_data", int'(bus4.tap_data), (j >= 0) ? hist[j] : 0);
            check("tap_addr", int'(bus4.ram_addr), j & 7);
            check("tap_last", int'(bus4.tap_last), (k == 3) ? 1 : 0);
            tapcnt++;
        end
        if (bus4.s_valid && bus4.s_ready) begin
            hist.push_back(int'(bus4.s_data));
            accepts++;
        end
        if (bus8.tap_valid && bus8.tap_ready) begin
            tap8.push_back(int'(bus8.tap_data));
            addr8.push_back(int'(bus8.ram_addr));
        end
    endtask

    task automatic sample_edge();
        @(negedge CLK);
        if (RST) scoreboard();
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST = 1'b0;
        model_reset();
        next_cycle();
        next_cycle();
        RST = 1'b1;
    endtask

    task automatic send4(input int d, input bit rnd);
        bit hs;
        hs = 1'b0;
        bus4.s_valid = 1'b1;
        bus4.s_data  = 6'(d);
        for (int c = 0; c < 200 && !hs; c++) begin
            sample_edge();
            hs = bus4.s_valid && bus4.s_ready;
            next_cycle();
            if (rnd) bus4.tap_ready = ($urandom_range(0, 3) != 0);
        end
        bus4.s_valid = 1'b0;
        if (!hs) timeout("send4");
    endtask

    task automatic wait_idle4();
        bit done;
        done = 1'b0;
        bus4.tap_ready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            sample_edge();
            done = bus4.s_ready;
            next_cycle();
        end
        if (!done) timeout("wait_idle4");
    endtask

    initial begin
        // sv sd tr | s_ready we addr din tap_valid idx last data
        vecs[0]  = '{1'b1, 6'd5,  1'b1, 1'b1, 1'b0, 3'd0, 6'd0,  1'b0, 4'd0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 3'd0, 6'd5,  1'b0, 4'd0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd0, 6'd5,  1'b1, 4'd0, 1'b0, 6'd5};
        vecs[3]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd7, 6'd5,  1'b1, 4'd1, 1'b0, 6'd0};
        vecs[4]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd6, 6'd5,  1'b1, 4'd2, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd5, 6'd5,  1'b1, 4'd3, 1'b1, 6'd0};
        vecs[6]  = '{1'b1, 6'd9,  1'b0, 1'b1, 1'b0, 3'd1, 6'd5,  1'b0, 4'd0, 1'b0, 6'd0};
        vecs[7]  = '{1'b0, 6'd9,  1'b0, 1'b0, 1'b1, 3'd1, 6'd9,  1'b0, 4'd0, 1'b0, 6'd0};
        vecs[8]  = '{1'b1, 6'd33, 1'b1, 1'b0, 1'b0, 3'd1, 6'd9,  1'b1, 4'd0, 1'b0, 6'd9};
        vecs[9]  = '{1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 3'd0, 6'd9,  1'b1, 4'd1, 1'b0, 6'd5};
        vecs[10] = '{1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 3'd0, 6'd9,  1'b1, 4'd1, 1'b0, 6'd5};
        vecs[11] = '{1'b1, 6'd33, 1'b0, 1'b0, 1'b0, 3'd0, 6'd9,  1'b1, 4'd1, 1'b0, 6'd5};
        vecs[12] = '{1'b1, 6'd33, 1'b1, 1'b0, 1'b0, 3'd0, 6'd9,  1'b1, 4'd1, 1'b0, 6'd5};
        vecs[13] = '{1'b1, 6'd33, 1'b1, 1'b0, 1'b0, 3'd7, 6'd9,  1'b1, 4'd2, 1'b0, 6'd0};
        vecs[14] = '{1'b1, 6'd33, 1'b1, 1'b0, 1'b0, 3'd6, 6'd9,  1'b1, 4'd3, 1'b1, 6'd0};
        vecs[15] = '{1'b1, 6'd33, 1'b1, 1'b1, 1'b0, 3'd2, 6'd9,  1'b0, 4'd0, 1'b0, 6'd0};
        vecs[16] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b1, 3'd2, 6'd33, 1'b0, 4'd0, 1'b0, 6'd0};
        vecs[17] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd2, 6'd33, 1'b1, 4'd0, 1'b0, 6'd33};
        vecs[18] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd1, 6'd33, 1'b1, 4'd1, 1'b0, 6'd9};
        vecs[19] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd0, 6'd33, 1'b1, 4'd2, 1'b0, 6'd5};
        vecs[20] = '{1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 3'd7, 6'd33, 1'b1, 4'd3, 1'b1, 6'd0};
        vecs[21] = '{1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 3'd3, 6'd33, 1'b0, 4'd0, 1'b0, 6'd0};

        bus4.s_valid = 1'b0; bus4.s_data = '0; bus4.tap_ready = 1'b0;
        bus8.s_valid = 1'b0; bus8.s_data = '0; bus8.tap_ready = 1'b1;

        // Reset state while RST is held low.
        #1;
        check("rst_s_ready", int'(bus4.s_ready), 0);
        check("rst_ram_we", int'(bus4.ram_we), 0);
        check("rst_ram_addr", int'(bus4.ram_addr), 0);
        check("rst_ram_din", int'(bus4.ram_din), 0);
        check("rst_tap_valid", int'(bus4.tap_valid), 0);
        check("rst_tap_idx", int'(bus4.tap_idx), 0);
        check("rst_tap_last", int'(bus4.tap_last), 0);
        next_cycle();
        next_cycle();
        RST = 1'b1;
        #1;
        check("rel_s_ready", int'(bus4.s_ready), 1);
        next_cycle();

        for (int i = 0; i < 22; i++) begin
            bus4.s_valid   = vecs[i].sv;
            bus4.s_data    = vecs[i].sd;
            bus4.tap_ready = vecs[i].tr;
            sample_edge();
            check($sformatf("v%0d_s_ready", i), int'(bus4.s_ready), int'(vecs[i].e_sr));
            check($sformatf("v%0d_ram_we", i), int'(bus4.ram_we), int'(vecs[i].e_we));
            check($sformatf("v%0d_ram_addr", i), int'(bus4.ram_addr), int'(vecs[i].e_addr));
            check($sformatf("v%0d_ram_din", i), int'(bus4.ram_din), int'(vecs[i].e_din));
            check($sformatf("v%0d_tap_valid", i), int'(bus4.tap_valid), int'(vecs[i].e_tv));
            check($sformatf("v%0d_tap_idx", i), int'(bus4.tap_idx), int'(vecs[i].e_idx));
            check($sformatf("v%0d_tap_last", i), int'(bus4.tap_last), int'(vecs[i].e_last));
            check($sformatf("v%0d_tap_data", i), int'(bus4.tap_data), int'(vecs[i].e_data));
            next_cycle();
        end
        bus4.s_valid = 1'b0;

        // Ten samples back-to-back from reset: pointer wraps and ends at 2.
        apply_reset();
        bus4.tap_ready = 1'b1;
        for (int d = 1; d <= 10; d++) send4(d, 1'b0);
        wait_idle4();
        #1;
        check("wrap_wptr", int'(bus4.ram_addr), 2);

        // Randomized traffic with gaps and random backpressure.
        for (int s = 0; s < 40; s++) begin
            send4(int'($urandom_range(0, 63)), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                sample_edge();
                next_cycle();
                bus4.tap_ready = ($urandom_range(0, 3) != 0);
            end
        end
        wait_idle4();

        // Asynchronous reset in the middle of a burst at k = 2.
        begin
            bit found;
            found = 1'b0;
            bus4.tap_ready = 1'b1;
            send4(21, 1'b0);
            for (int c = 0; c < 20 && !found; c++) begin
                sample_edge();
                found = bus4.tap_valid && (bus4.tap_idx == 4'd2);
                if (!found) next_cycle();
            end
            if (!found) timeout("reach_k2");
            #2;
            RST = 1'b0;
            #1;
            check("arst_s_ready", int'(bus4.s_ready), 0);
            check("arst_tap_valid", int'(bus4.tap_valid), 0);
            check("arst_ram_addr", int'(bus4.ram_addr), 0);
            check("arst_tap_idx", int'(bus4.tap_idx), 0);
            check("arst_tap_last", int'(bus4.tap_last), 0);
            check("arst_ram_din", int'(bus4.ram_din), 0);
            model_reset();
            next_cycle();
            next_cycle();
            RST = 1'b1;
            send4(44, 1'b0);
            wait_idle4();
        end

        // TAPS = 8 instance: eight samples fill every word.
        for (int d = 1; d <= 8; d++) begin
            bit hs;
            hs = 1'b0;
            bus8.s_valid = 1'b1;
            bus8.s_data  = 6'(d);
            for (int c = 0; c < 30 && !hs; c++) begin
                sample_edge();
                hs = bus8.s_ready;
                next_cycle();
            end
            bus8.s_valid = 1'b0;
            if (!hs) timeout("send8");
        end
        repeat (12) begin
            sample_edge();
            next_cycle();
        end
        check("t8_tap_count", tap8.size(), 64);
        if (tap8.size() == 64) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t8_data%0d", i), tap8[56+i], 8 - i);
                check($sformatf("t8_addr%0d", i), addr8[56+i], 7 - i);
            end
        end

        check("write_count", writes, accepts);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_tap_sequencer.md
Name: ram_tap_sequencer

Overview:
- Drives the port of the team's asynchronous-read / synchronous-write RAM (RAM_ar) as a circular sample delay line for the IIR filter datapath.
- Per accepted input sample: one write of the sample at the write pointer, then TAPS sequential reads, newest first (x[n], x[n-1], …), streamed to the MAC stage over a valid/ready handshake.
- Sits between the sample source and the IIR MAC; the parent instantiates the RAM beside it.

Parameters:
- eleNum, 8, RAM depth in words; must match the attached RAM's eleNum.
- dataWidth, 6, sample width in bits; must match the RAM.
- TAPS, 8, reads per sample; legal range 1..2**addWidth.
- addWidth (localparam), ceil(log2(eleNum)), address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  dataWidth  input sample.
- ram_we  out  1  RAM write enable.
- ram_addr  out  addWidth  RAM address.
- ram_din  out  dataWidth  RAM write data.
- ram_dout  in  dataWidth  RAM asynchronous read data.
- tap_valid  out  1  tap word valid.
- tap_ready  in  1  consumer accepts the tap.
- tap_data  out  dataWidth  tap sample, equal to ram_dout (combinational through the RAM).
- tap_idx  out  addWidth+1  delay index k of the current tap (0 = newest).
- tap_last  out  1  high with tap_valid when k = TAPS-1.

Behaviour:
- Reset (RST low, async):
  - state = IDLE, wptr = 0, k = 0, sample register = 0.
  - Outputs: s_ready = 0 while RST is low, 1 after release; ram_we = 0, ram_addr = 0, ram_din = 0, tap_valid = 0, tap_idx = 0, tap_last = 0.
  - Reset mid-operation abandons the burst; no partial write persists beyond what the RAM has already clocked.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - s_ready = 1, ram_we = 0, ram_addr = wptr.
  - On s_valid & s_ready: latch s_data into the sample register; go to WRITE.
- WRITE (exactly 1 cycle):
  - s_ready = 0, ram_we = 1, ram_addr = wptr, ram_din = sample register; go to READ with k = 0.
- READ:
  - s_ready = 0, ram_we = 0, ram_addr = (wptr - k) mod 2**addWidth. Arithmetic is addWidth-bit unsigned with natural wrap, so wptr = 0, k = 1 gives address 2**addWidth-1.
  - tap_valid = 1, tap_idx = k, tap_last = (k == TAPS-1).
  - On tap_ready with k < TAPS-1: k increments.
  - On tap_ready with k = TAPS-1: wptr increments (wraps 2**addWidth-1 -> 0), k = 0, go to IDLE.
  - tap_ready low: hold address, k and tap_valid; tap_data stays stable because the RAM is not written in READ.
- Latency:
  - Sample accepted at cycle c; write occurs at the edge ending cycle c+1.
  - First tap (k = 0, the new sample) is valid in cycle c+2.
  - With tap_ready tied high, one sample costs TAPS+2 cycles; s_ready returns in cycle c+2+TAPS.
- Boundary conditions:
  - Before the line fills, taps at older locations read the RAM reset contents (0). This block does not mask them.
  - s_valid while busy is ignored (s_ready = 0); the source must hold the sample.
  - TAPS = 2**addWidth reads every word, the oldest being x[n-2**addWidth+1].
  - tap_ready high while tap_valid is low has no effect.

Decomposition:
- Shared package: log2 ceiling function, the state encodings (IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2), and the default width/depth constants shared with the IIR top.
- No sub-module: the FSM and pointer arithmetic stay in one module. The bench and the IIR top instantiate RAM_ar next to it.

Test Plan (eleNum = 8, dataWidth = 6, TAPS = 4):
- Reset then a single sample 6'd5, tap_ready = 1 -> one ram_we pulse at addr 0 with din 5; taps 5, 0, 0, 0 at addr 0, 7, 6, 5; tap_idx 0..3; tap_last on the 4th tap only; s_ready high again 6 cycles after acceptance.
- Ten samples 1..10 back-to-back -> after sample 10 (wptr = 1 at write), taps are 10, 9, 8, 7 from addr 1, 0, 7, 6; wptr ends at 2 (wrap check).
- Backpressure: tap_ready low for 3 cycles on k = 1 -> tap_valid, tap_idx = 1, ram_addr and tap_data held; no skipped or repeated tap after release.
- s_valid held during READ with a new s_data -> not accepted until IDLE; exactly one write per handshake; a total count mismatch fails.
- RST pulsed low mid-READ (k = 2) -> outputs drop to reset values asynchronously without waiting for a CLK edge; after release, the next sample writes addr 0 and its older taps read 0.
- TAPS = 8 build, 8 samples 1..8 -> taps 8, 7, 6, 5, 4, 3, 2, 1 covering all addresses.
